// File: rtl/cart_rom_ctl.sv
// rtl/cart_rom_ctl.sv - cartridge ROM port arbiter: HPS load, small-image mirror fill, console fetch
module cart_rom_ctl #(
    parameter int HOLD_CYCLES = 16,
    parameter int FILL_SIZE   = 4096
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic [16:0] rom_size,
    output logic        core_reset,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, LOAD, FILL_RD, FILL_WR, HOLD} state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [16:0]   FILL_LIM  = 17'(FILL_SIZE);
    localparam logic [14:0]   FILL_LAST = 15'(FILL_SIZE - 1);

    state_t        state;
    logic          dl_q;
    logic          pass_q;
    logic [14:0]   src;
    logic [14:0]   dst;
    logic [HW-1:0] hold_cnt;

    logic          dl_rise;
    logic          dl_fall;
    logic          load_wr;
    logic [16:0]   wr_end;
    logic [16:0]   rom_next;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign load_wr  = (state == LOAD) && ioctl_wr && (ioctl_addr[24:15] == 10'd0);
    assign wr_end   = {2'b00, ioctl_addr[14:0]} + 17'd1;
    // Size seen at the falling edge must include a write landing in that same cycle
    assign rom_next = (load_wr && (wr_end > rom_size)) ? wr_end : rom_size;

    assign cpu_data   = pass_q ? mem_dout : 8'hFF;
    assign core_reset = reset | (state != IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        mem_addr = 15'd0;
        mem_we   = 1'b0;
        mem_din  = 8'd0;
        if (!reset) begin
            case (state)
                IDLE: mem_addr = cpu_addr;
                LOAD: begin
                    mem_addr = ioctl_addr[14:0];
                    if (load_wr) begin
                        mem_we  = 1'b1;
                        mem_din = ioctl_dout;
                    end
                end
                FILL_RD: mem_addr = src;
                FILL_WR: begin
                    mem_addr = dst;
                    mem_we   = 1'b1;
                    mem_din  = mem_dout;
                end
                default: mem_addr = 15'd0;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            dl_q     <= 1'b0;
            pass_q   <= 1'b0;
            rom_size <= 17'd0;
            src      <= 15'd0;
            dst      <= 15'd0;
            hold_cnt <= '0;
        end else begin
            dl_q   <= ioctl_download;
            pass_q <= (state == IDLE);
            case (state)
                IDLE: begin
                    if (dl_rise) begin
                        state    <= LOAD;
                        rom_size <= 17'd0;
                    end
                end
                LOAD: begin
                    rom_size <= rom_next;
                    if (dl_fall) begin
                        if ((rom_next != 17'd0) && (rom_next < FILL_LIM)) begin
                            state <= FILL_RD;
                            src   <= 15'd0;
                            dst   <= rom_next[14:0];
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                FILL_RD: state <= FILL_WR;
                FILL_WR: begin
                    dst      <= dst + 15'd1;
                    // Wrap instead of modulo: src walks the image cyclically
                    src      <= (({2'b00, src} + 17'd1) == rom_size) ? 15'd0 : src + 15'd1;
                    hold_cnt <= '0;
                    state    <= (dst == FILL_LAST) ? HOLD : FILL_RD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (dl_rise && (state == FILL_RD || state == FILL_WR || state == HOLD)) begin
                state    <= LOAD;
                rom_size <= 17'd0;
            end
        end
    end
endmodule

// File: tb/tb_cart_rom_ctl.sv
// tb/tb_cart_rom_ctl.sv - scoreboard bench for cart_rom_ctl with a behavioural sync RAM
module tb_cart_rom_ctl;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [16:0] rom_size;
    logic        core_reset;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:32767];
    logic [7:0] exp_mem [0:32767];
    logic [7:0] exp_q [$];

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    cart_rom_ctl #(.HOLD_CYCLES(16), .FILL_SIZE(4096)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .rom_size(rom_size), .core_reset(core_reset), .busy(busy)
    );

    function automatic logic [7:0] data_of(input int kind, input int i);
        logic [31:0] v;
        if (kind == 0) v = i;
        else if (kind == 1) v = i * 7 + 3;
        else v = (i == 0) ? 32'hAA : (i == 1) ? 32'hBB : 32'hCC;
        return v[7:0];
    endfunction

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit last);
        bit ok;
        ioctl_wr = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (last) ioctl_download = 1'b0;
        ok = (a[24:15] == 10'd0);
        if (ok) exp_mem[a[14:0]] = d;
        @(negedge clk_sys);
        checks++;
        if (mem_we !== ok || (ok && (mem_addr !== a[14:0] || mem_din !== d))) begin
            errors++;
            $display("FAIL wr_path a=%h: we=%b addr=%h din=%h, expected we=%b din=%h", a, mem_we, mem_addr, mem_din, ok, d);
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_load;
        ioctl_download = 1'b1;
        tick;
        tick;
        @(negedge clk_sys);
        checks++;
        if (cpu_data !== 8'hFF || busy !== 1'b1 || core_reset !== 1'b1 || rom_size !== 17'd0) begin
            errors++;
            $display("FAIL load_entry: cpu_data=%h busy=%b core_reset=%b rom_size=%0d, expected FF 1 1 0", cpu_data, busy, core_reset, rom_size);
        end
        tick;
    endtask

    task automatic do_load(input int n, input int kind);
        start_load;
        for (int i = 0; i < n; i++) wr_byte(25'(i), data_of(kind, i), i == n - 1);
        ioctl_wr = 1'b0;
        if (n < 4096) for (int i = n; i < 4096; i++) exp_mem[i] = exp_mem[i % n];
    endtask

    // Entered one cycle after the download-falling cycle
    task automatic wait_idle(input int exp_cycles, input string name);
        int n = 1;
        bit done = 0;
        while (!done && n < 20000) begin
            @(negedge clk_sys);
            if (!core_reset) done = 1;
            else begin
                @(posedge clk_sys);
                n++;
            end
        end
        checks++;
        if (!done || n != exp_cycles) begin
            errors++;
            $display("FAIL %s: core_reset fell after %0d cycles (done=%0d), expected %0d", name, n, done, exp_cycles);
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_size(input logic [16:0] e, input string name);
        checks++;
        if (rom_size !== e) begin
            errors++;
            $display("FAIL %s: rom_size=%0d expected %0d", name, rom_size, e);
        end
    endtask

    task automatic read_check(input int addrs[$]);
        logic [7:0] e;
        for (int i = 0; i <= addrs.size(); i++) begin
            if (i < addrs.size()) begin
                cpu_addr = 15'(addrs[i]);
                exp_q.push_back(exp_mem[addrs[i]]);
            end
            @(negedge clk_sys);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (cpu_data !== e) begin
                    errors++;
                    $display("FAIL fetch addr=%h: cpu_data=%h expected %h", addrs[i-1], cpu_data, e);
                end
            end
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = 25'd0;
        ioctl_dout = 8'd0;
        cpu_addr = 15'h1234;
        repeat (3) tick;
        @(negedge clk_sys);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_din !== 8'd0 || rom_size !== 17'd0 ||
            core_reset !== 1'b1 || busy !== 1'b0 || cpu_data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_state: we=%b addr=%h din=%h size=%0d crst=%b busy=%b data=%h", mem_we, mem_addr, mem_din, rom_size, core_reset, busy, cpu_data);
        end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        tick;
        @(negedge clk_sys);
        checks++;
        if (core_reset !== 1'b0 || busy !== 1'b0 || mem_addr !== 15'h1234) begin
            errors++;
            $display("FAIL reset_release: crst=%b busy=%b mem_addr=%h expected 0 0 1234", core_reset, busy, mem_addr);
        end
        tick;
    endtask

    task automatic test_full_4096;
        do_load(4096, 0);
        wait_idle(17, "hold_4096");
        check_size(17'd4096, "size_4096");
        checks++;
        if (exp_mem[15'h0123] !== 8'h23) begin
            errors++;
            $display("FAIL model_0123: %h expected 23", exp_mem[15'h0123]);
        end
        read_check('{32'h0123, 0, 32'h0FFF, 32'h0800});
    endtask

    task automatic test_fill_2048;
        int a[$];
        do_load(2048, 1);
        wait_idle(2 * 2048 + 17, "fill_2048");
        check_size(17'd2048, "size_2048");
        a = '{32'h0800, 32'h0FFF, 0, 32'h07FF};
        for (int i = 0; i < 12; i++) a.push_back($urandom_range(4095, 0));
        read_check(a);
    endtask

    task automatic test_fill_3;
        int a[$];
        do_load(3, 2);
        wait_idle(2 * 4093 + 17, "fill_3");
        check_size(17'd3, "size_3");
        a = '{0, 1, 2, 3, 4, 5, 4093, 4094, 4095};
        for (int i = 0; i < 8; i++) a.push_back($urandom_range(4095, 0));
        read_check(a);
    endtask

    task automatic test_drop_high;
        start_load;
        for (int i = 0; i < 16; i++) wr_byte(25'(i), 8'(8'hC0 + i), 1'b0);
        wr_byte(25'h7FFF, 8'h77, 1'b0);
        wr_byte(25'h8000, 8'hEE, 1'b0);
        wr_byte(25'h10000, 8'hDD, 1'b1);
        ioctl_wr = 1'b0;
        wait_idle(17, "hold_32k");
        check_size(17'd32768, "size_32k");
        read_check('{0, 1, 15, 32'h7FFF});
    endtask

    task automatic test_abort;
        bit bad = 0;
        do_load(1024, 1);
        repeat (100) tick;
        @(negedge clk_sys);
        checks++;
        if (busy !== 1'b1 || rom_size !== 17'd1024) begin
            errors++;
            $display("FAIL mid_fill: busy=%b size=%0d expected 1 1024", busy, rom_size);
        end
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b1;
        tick;
        @(negedge clk_sys);
        checks++;
        if (busy !== 1'b1 || rom_size !== 17'd0 || core_reset !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b size=%0d crst=%b we=%b expected 1 0 1 0", busy, rom_size, core_reset, mem_we);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            if (mem_we !== 1'b0 || core_reset !== 1'b1) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_quiet: write or core_reset drop seen after abort, expected none");
        end
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b0;
        tick;
        wait_idle(17, "hold_empty");
        check_size(17'd0, "size_empty");
    endtask

    task automatic test_reset_in_load;
        start_load;
        for (int i = 0; i < 4; i++) wr_byte(25'(32'h200 + i), 8'(8'h31 + i), 1'b0);
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'h300;
        ioctl_dout = 8'h99;
        @(negedge clk_sys);
        checks++;
        if (mem_we !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_gate: we=%b crst=%b expected 0 1", mem_we, core_reset);
        end
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (busy !== 1'b0 || rom_size !== 17'd0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_load: busy=%b size=%0d we=%b expected 0 0 0", busy, rom_size, mem_we);
        end
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        tick;
        read_check('{32'h200, 32'h201, 32'h203, 32'h300});
    endtask

    initial begin
        test_reset;
        test_full_4096;
        test_fill_2048;
        test_fill_3;
        test_drop_high;
        test_abort;
        test_reset_in_load;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
